// File: rtl/pulse_train_if.sv
// Start-block link for pulse_train: start level, per-channel multipliers,
// pulse drive, completion flag and status.
interface pulse_train_if;
    // Level handshake: the start block raises st_o and keeps it high;
    // pulse_train raises end_flg when the sequence completes and holds it
    // until st_o is seen low. st_o low during a run aborts it.
    logic       st_o;
    logic [4:0] MPL1, MPL2, MPL3, MPL4, MPL5, MPL6, MPL7, MPL8;
    logic [4:0] MPL9, MPL10, MPL11, MPL12, MPL13, MPL14, MPL15, MPL16;
    logic       pulse_o;
    logic       end_flg;
    logic       busy;
    logic [3:0] ch_idx;
    logic [2:0] state_dbg;

    modport master (
        output st_o, MPL1, MPL2, MPL3, MPL4, MPL5, MPL6, MPL7, MPL8,
               MPL9, MPL10, MPL11, MPL12, MPL13, MPL14, MPL15, MPL16,
        input  pulse_o, end_flg, busy, ch_idx, state_dbg
    );

    modport slave (
        input  st_o, MPL1, MPL2, MPL3, MPL4, MPL5, MPL6, MPL7, MPL8,
               MPL9, MPL10, MPL11, MPL12, MPL13, MPL14, MPL15, MPL16,
        output pulse_o, end_flg, busy, ch_idx, state_dbg
    );
endinterface

// File: rtl/pulse_train.sv
// Sixteen-channel optical sync pulse sequencer: one pulse of MPL*UNIT_CYC
// cycles per non-zero channel, each followed by a GAP_CYC low gap.
module pulse_train #(
    parameter int unsigned UNIT_CYC = 8,
    parameter int unsigned GAP_CYC  = 4
) (
    input  logic         st_clk,
    input  logic         st_rst_n,
    pulse_train_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PULSE = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] UNIT_W   = 16'(UNIT_CYC);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

    state_t      state;
    logic        rst_sync_n;
    logic        st_prev;
    logic [15:0] cnt;
    logic [4:0]  shadow [16];
    logic        pulse_r;
    logic        end_r;
    logic        busy_r;
    logic [3:0]  ch_r;
    logic [4:0]  cur_mpl;
    logic [15:0] pulse_last;
    logic        running;

    assign cur_mpl    = shadow[ch_r];
    // 31*2048 = 63488 still fits in 16 bits, so the product never wraps.
    assign pulse_last = 16'(cur_mpl) * UNIT_W - 16'd1;
    assign running    = (state == LOAD) || (state == PULSE) || (state == GAP);

    assign bus.pulse_o   = pulse_r;
    assign bus.end_flg   = end_r;
    assign bus.busy      = busy_r;
    assign bus.ch_idx    = ch_r;
    assign bus.state_dbg = state;

    // Assert asynchronously, release on the first edge so the second edge
    // after release is the first one the sequencer acts on.
    always_ff @(posedge st_clk or negedge st_rst_n) begin
        if (!st_rst_n) rst_sync_n <= 1'b0;
        else           rst_sync_n <= 1'b1;
    end

    always_ff @(posedge st_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state   <= IDLE;
            st_prev <= 1'b1;
            cnt     <= '0;
            pulse_r <= 1'b0;
            end_r   <= 1'b0;
            busy_r  <= 1'b0;
            ch_r    <= '0;
            for (int i = 0; i < 16; i++) shadow[i] <= '0;
        end else begin
            st_prev <= bus.st_o;
            if (running && !bus.st_o) begin
                state   <= IDLE;
                pulse_r <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.st_o && !st_prev) begin
                            shadow[0]  <= bus.MPL1;
                            shadow[1]  <= bus.MPL2;
                            shadow[2]  <= bus.MPL3;
                            shadow[3]  <= bus.MPL4;
                            shadow[4]  <= bus.MPL5;
                            shadow[5]  <= bus.MPL6;
                            shadow[6]  <= bus.MPL7;
                            shadow[7]  <= bus.MPL8;
                            shadow[8]  <= bus.MPL9;
                            shadow[9]  <= bus.MPL10;
                            shadow[10] <= bus.MPL11;
                            shadow[11] <= bus.MPL12;
                            shadow[12] <= bus.MPL13;
                            shadow[13] <= bus.MPL14;
                            shadow[14] <= bus.MPL15;
                            shadow[15] <= bus.MPL16;
                            ch_r       <= '0;
                            busy_r     <= 1'b1;
                            state      <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (cur_mpl != 5'd0) begin
                            cnt     <= pulse_last;
                            pulse_r <= 1'b1;
                            state   <= PULSE;
                        end else if (ch_r != 4'd15) begin
                            ch_r <= ch_r + 4'd1;
                        end else begin
                            end_r  <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= DONE;
                        end
                    end
                    PULSE: begin
                        if (cnt == 16'd0) begin
                            cnt     <= GAP_LAST;
                            pulse_r <= 1'b0;
                            state   <= GAP;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    GAP: begin
                        if (cnt != 16'd0) begin
                            cnt <= cnt - 16'd1;
                        end else if (ch_r != 4'd15) begin
                            ch_r  <= ch_r + 4'd1;
                            state <= LOAD;
                        end else begin
                            end_r  <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= DONE;
                        end
                    end
                    DONE: begin
                        if (!bus.st_o) begin
                            end_r <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        pulse_r <= 1'b0;
                        end_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pulse_train.sv
// Bench for pulse_train: table vectors with hand-derived timing, hand-written
// abort/re-arm/reset sequences, and random MPL sets checked cycle by cycle.
module tb_pulse_train;
    localparam int UNIT = 8;
    localparam int GAPC = 4;

    typedef logic [4:0] mpl_arr_t [16];
    typedef struct {
        int sel_ch;
        int sel_val;
        int fill_val;
        int exp_rise;
        int exp_high;
        int exp_done;
    } vec_t;

    logic st_clk;
    logic st_rst_n;
    int   checks;
    int   errors;
    logic [6:0] exp_q [$];

    pulse_train_if bus_if ();

    pulse_train #(.UNIT_CYC(UNIT), .GAP_CYC(GAPC)) dut (
        .st_clk  (st_clk),
        .st_rst_n(st_rst_n),
        .bus     (bus_if)
    );

    // Clock and watchdog
    initial begin
        st_clk = 1'b0;
        forever #5 st_clk = ~st_clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_mpl(input mpl_arr_t m);
        bus_if.MPL1  = m[0];  bus_if.MPL2  = m[1];  bus_if.MPL3  = m[2];  bus_if.MPL4  = m[3];
        bus_if.MPL5  = m[4];  bus_if.MPL6  = m[5];  bus_if.MPL7  = m[6];  bus_if.MPL8  = m[7];
        bus_if.MPL9  = m[8];  bus_if.MPL10 = m[9];  bus_if.MPL11 = m[10]; bus_if.MPL12 = m[11];
        bus_if.MPL13 = m[12]; bus_if.MPL14 = m[13]; bus_if.MPL15 = m[14]; bus_if.MPL16 = m[15];
    endtask

    // Reference: expected {pulse_o, end_flg, busy, ch_idx} for each cycle
    // from cycle 1 (LOAD ch0) through the first DONE cycle.
    task automatic build_model(input mpl_arr_t m);
        exp_q.delete();
        for (int ch = 0; ch < 16; ch++) begin
            exp_q.push_back({3'b001, 4'(ch)});
            if (m[ch] != 5'd0) begin
                repeat (int'(m[ch]) * UNIT) exp_q.push_back({3'b101, 4'(ch)});
                repeat (GAPC) exp_q.push_back({3'b001, 4'(ch)});
            end
        end
        exp_q.push_back({3'b010, 4'd15});
    endtask

    function automatic logic [6:0] dut_out();
        return {bus_if.pulse_o, bus_if.end_flg, bus_if.busy, bus_if.ch_idx};
    endfunction

    // Called at a negedge with st_o low and the DUT idle; leaves it in DONE with st_o high.
    task automatic run_seq(input mpl_arr_t m, output int rise, output int high, output int done);
        mpl_arr_t junk;
        logic [6:0] e;
        int c;
        set_mpl(m);
        build_model(m);
        rise = -1; high = 0; done = -1;
        bus_if.st_o = 1'b1;
        @(negedge st_clk);
        for (int i = 0; i < 16; i++) junk[i] = 5'($urandom_range(0, 31));
        set_mpl(junk);
        c = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("cycle%0d", c), 32'(dut_out()), 32'(e));
            if (bus_if.pulse_o === 1'b1) begin
                high++;
                if (rise < 0) rise = c;
            end
            if (bus_if.end_flg === 1'b1 && done < 0) done = c;
            c++;
            @(negedge st_clk);
        end
        repeat (3) begin
            check("done_hold", 32'({bus_if.pulse_o, bus_if.end_flg, bus_if.busy}), 32'(3'b010));
            @(negedge st_clk);
        end
    endtask

    task automatic finish_seq();
        bus_if.st_o = 1'b0;
        @(negedge st_clk);
        check("done_exit", 32'({bus_if.pulse_o, bus_if.end_flg, bus_if.busy}), 32'(3'b000));
    endtask

    initial begin
        vec_t     vecs [6];
        mpl_arr_t m;
        int rise, high, done;

        checks = 0;
        errors = 0;
        vecs[0] = '{sel_ch: 0,  sel_val: 1,  fill_val: 0, exp_rise: 2,  exp_high: 8,   exp_done: 29};
        vecs[1] = '{sel_ch: 0,  sel_val: 0,  fill_val: 0, exp_rise: -1, exp_high: 0,   exp_done: 17};
        vecs[2] = '{sel_ch: 15, sel_val: 31, fill_val: 0, exp_rise: 17, exp_high: 248, exp_done: 269};
        vecs[3] = '{sel_ch: 0,  sel_val: 1,  fill_val: 1, exp_rise: 2,  exp_high: 128, exp_done: 209};
        vecs[4] = '{sel_ch: 7,  sel_val: 3,  fill_val: 0, exp_rise: 9,  exp_high: 24,  exp_done: 45};
        vecs[5] = '{sel_ch: 0,  sel_val: 2,  fill_val: 0, exp_rise: 2,  exp_high: 16,  exp_done: 37};

        // Reset
        st_rst_n = 1'b0;
        bus_if.st_o = 1'b0;
        for (int i = 0; i < 16; i++) m[i] = '0;
        set_mpl(m);
        repeat (3) @(negedge st_clk);
        check("reset_out", 32'(dut_out()), 32'(7'd0));
        st_rst_n = 1'b1;
        repeat (3) @(negedge st_clk);
        check("post_reset", 32'(dut_out()), 32'(7'd0));

        // Table vectors
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 16; i++) m[i] = 5'(vecs[v].fill_val);
            m[vecs[v].sel_ch] = 5'(vecs[v].sel_val);
            run_seq(m, rise, high, done);
            check($sformatf("vec%0d_rise", v), 32'(rise), 32'(vecs[v].exp_rise));
            check($sformatf("vec%0d_high", v), 32'(high), 32'(vecs[v].exp_high));
            check($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
            finish_seq();
        end

        // Held high through DONE: no retrigger; one low cycle re-arms
        for (int i = 0; i < 16; i++) m[i] = '0;
        m[2] = 5'd1;
        run_seq(m, rise, high, done);
        repeat (20) begin
            check("no_retrigger", 32'({bus_if.pulse_o, bus_if.end_flg, bus_if.busy}), 32'(3'b010));
            @(negedge st_clk);
        end
        bus_if.st_o = 1'b0;
        @(negedge st_clk);
        m[2] = 5'd0;
        m[5] = 5'd2;
        run_seq(m, rise, high, done);
        check("rearm_rise", 32'(rise), 32'(7));
        finish_seq();

        // Abort mid-pulse
        for (int i = 0; i < 16; i++) m[i] = '0;
        m[0] = 5'd2;
        set_mpl(m);
        bus_if.st_o = 1'b1;
        repeat (5) @(negedge st_clk);
        check("abort_pre_pulse", 32'(bus_if.pulse_o), 32'(1));
        bus_if.st_o = 1'b0;
        @(negedge st_clk);
        check("abort_out", 32'({bus_if.pulse_o, bus_if.end_flg, bus_if.busy}), 32'(3'b000));
        repeat (5) begin
            @(negedge st_clk);
            check("abort_no_end", 32'({bus_if.pulse_o, bus_if.end_flg, bus_if.busy}), 32'(3'b000));
        end
        m[0] = 5'd1;
        run_seq(m, rise, high, done);
        check("restart_done", 32'(done), 32'(29));
        finish_seq();

        // Reset during PULSE
        for (int i = 0; i < 16; i++) m[i] = '0;
        m[0] = 5'd4;
        set_mpl(m);
        bus_if.st_o = 1'b1;
        repeat (5) @(negedge st_clk);
        check("rst_pre_pulse", 32'(bus_if.pulse_o), 32'(1));
        #2 st_rst_n = 1'b0;
        #1 check("rst_async", 32'(dut_out()), 32'(7'd0));
        @(negedge st_clk);
        st_rst_n = 1'b1;
        repeat (6) begin
            @(negedge st_clk);
            check("rst_no_start", 32'(dut_out()), 32'(7'd0));
        end
        bus_if.st_o = 1'b0;
        @(negedge st_clk);

        // Random MPL sets
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 7) == 0)      m[i] = 5'd31;
                else if ($urandom_range(0, 2) == 0) m[i] = 5'd0;
                else                                m[i] = 5'($urandom_range(1, 4));
            end
            run_seq(m, rise, high, done);
            finish_seq();
            repeat ($urandom_range(0, 3)) @(negedge st_clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
